vga_sync_gen: RTL and testbench

- Generates VGA raster timing for the display path: a pixel-rate tick, the horizontal and vertical position counters, and the sync/blanking signals.
- Sits directly upstream of the video-memory adapter, which maps widthPos/heightPos (10-bit each) onto 40x40-pixel cells of a 16x12 grid.
- Also drives the hsync/vsync pins and gates RGB with `visible`.
- Default timing is 640x480 @ 60 Hz from a 50 MHz clock (25 MHz pixel rate).

---
 rtl/vga_sync_gen.sv | 148 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA raster timing generator. A clock divider produces the pixel-rate
//   tick. Horizontal and vertical position counters advance on that tick.
//   A single registered output stage presents the position, the sync
//   levels and the visible-area decode, so all outputs change on the same
//   clk edge, one clk after the counters.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en         count enable; low freezes counters and outputs
//   widthPos   horizontal pixel position, 0..H_TOTAL-1
//   heightPos  vertical line position, 0..V_TOTAL-1
//   hsync      horizontal sync, equal to SYNC_POL while asserted
//   vsync      vertical sync, equal to SYNC_POL while asserted
//   visible    position lies inside the active picture
//   pixValid   one-clk strobe: the outputs took a new pixel this clk
//   frameStart one-clk strobe with pixValid when the outputs become (0,0)
//
// Handshake: pixValid/frameStart are pure strobes with no ready. Downstream
// logic samples the outputs on any clk where pixValid is high and must keep
// up with the pixel rate. en is the only back-pressure; while it is low,
// no strobe is issued and every other output holds.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] widthPos,
  output logic [9:0] heightPos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       pixValid,
  output logic       frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

  // Decode bounds are one bit wider than the counters so that a window
  // ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_ON  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] divCnt;
  logic [9:0]    hCount;
  logic [9:0]    vCount;
  logic          tick;
  // High for the clk after a tick: the counters hold a value the output
  // stage has not yet presented. It is held while en is low, so a tick
  // that lands just before en drops is still reported when en returns.
  logic          fresh;

  logic          h_in_sync;
  logic          v_in_sync;
  logic          in_visible;
  logic          at_origin;

  assign tick = en & (divCnt == DIV_LAST);

  always_comb begin
    h_in_sync  = 1'b0;
    v_in_sync  = 1'b0;
    in_visible = 1'b0;
    at_origin  = 1'b0;
    h_in_sync  = ({1'b0, hCount} >= H_SYNC_ON) && ({1'b0, hCount} < H_SYNC_OFF);
    v_in_sync  = ({1'b0, vCount} >= V_SYNC_ON) && ({1'b0, vCount} < V_SYNC_OFF);
    in_visible = ({1'b0, hCount} < H_VIS_END) && ({1'b0, vCount} < V_VIS_END);
    at_origin  = (hCount == 10'd0) && (vCount == 10'd0);
  end

  // Divider: free-runs while enabled, holds its phase while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt <= '0;
    end else if (en) begin
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
    end
  end

  // Position counters. The line wrap and frame wrap share one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (tick) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh <= 1'b0;
    end else if (en) begin
      fresh <= tick;
    end
  end

  // Output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widthPos   <= '0;
      heightPos  <= '0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      visible    <= 1'b0;
      pixValid   <= 1'b0;
      frameStart <= 1'b0;
    end else if (en) begin
      widthPos   <= hCount;
      heightPos  <= vCount;
      hsync      <= h_in_sync ? SYNC_POL : ~SYNC_POL;
      vsync      <= v_in_sync ? SYNC_POL : ~SYNC_POL;
      visible    <= in_visible;
      pixValid   <= fresh;
      frameStart <= fresh & at_origin;
    end else begin
      pixValid   <= 1'b0;
      frameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. Three instances share clk and rst:
//   a: default 640x480 timing, CLK_DIV=2, active-low syncs
//   b: default geometry, CLK_DIV=1, active-high syncs
//   c: a tiny 16x9 raster, CLK_DIV=3, so full frames fit in a short run;
//      its pixel stream is compared against an expected queue.
module tb_vga_sync_gen;

  // Small raster used by instance c.
  localparam int C_DIV = 3;
  localparam int C_HV = 8, C_HF = 2, C_HS = 3, C_HB = 3;
  localparam int C_VV = 4, C_VF = 1, C_VS = 2, C_VB = 2;
  localparam int C_HT = C_HV + C_HF + C_HS + C_HB;  // 16
  localparam int C_VT = C_VV + C_VF + C_VS + C_VB;  // 9
  localparam int D_HT = 640 + 16 + 96 + 48;         // 800
  localparam int D_VT = 480 + 10 + 2 + 33;          // 525

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b, en_c;
  always #5 clk = ~clk;

  logic [9:0] wp_a, hp_a, wp_b, hp_b, wp_c, hp_c;
  logic hs_a, vs_a, vis_a, pv_a, fs_a;
  logic hs_b, vs_b, vis_b, pv_b, fs_b;
  logic hs_c, vs_c, vis_c, pv_c, fs_c;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst), .en(en_a),
    .widthPos(wp_a), .heightPos(hp_a), .hsync(hs_a), .vsync(vs_a),
    .visible(vis_a), .pixValid(pv_a), .frameStart(fs_a)
  );

  vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b),
    .widthPos(wp_b), .heightPos(hp_b), .hsync(hs_b), .vsync(vs_b),
    .visible(vis_b), .pixValid(pv_b), .frameStart(fs_b)
  );

  vga_sync_gen #(
    .CLK_DIV(C_DIV),
    .H_VISIBLE(C_HV), .H_FRONT(C_HF), .H_SYNC(C_HS), .H_BACK(C_HB),
    .V_VISIBLE(C_VV), .V_FRONT(C_VF), .V_SYNC(C_VS), .V_BACK(C_VB),
    .SYNC_POL(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .en(en_c),
    .widthPos(wp_c), .heightPos(hp_c), .hsync(hs_c), .vsync(vs_c),
    .visible(vis_c), .pixValid(pv_c), .frameStart(fs_c)
  );

  initial begin
    if (D_HT > 1024 || D_VT > 1024 || C_HT > 1024 || C_VT > 1024) begin
      $display("FAIL raster_totals: a total exceeds 1024");
      $fatal(1, "raster totals out of range");
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [22:0] exp_q[$];  // {hsync, vsync, visible, heightPos, widthPos}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic test_a();
    int last_pv, line_start, pw, ph, w, h;
    bit found;
    @(negedge clk);  // edge 1: decode of (0,0)
    check("a_e1_w", 32'(wp_a), 0);
    check("a_e1_vis", 32'(vis_a), 1);
    check("a_e1_hs", 32'(hs_a), 1);
    check("a_e1_vs", 32'(vs_a), 1);
    check("a_e1_pv", 32'(pv_a), 0);
    @(negedge clk);  // edge 2: first tick, not yet on outputs
    check("a_e2_pv", 32'(pv_a), 0);
    check("a_e2_w", 32'(wp_a), 0);
    @(negedge clk);  // edge 3: first new pixel
    check("a_e3_pv", 32'(pv_a), 1);
    check("a_e3_w", 32'(wp_a), 1);
    last_pv = 3; line_start = 0; pw = 1; ph = 0;
    for (int e = 4; e <= 3300; e++) begin
      @(negedge clk);
      check("a_fs_idle", 32'(fs_a), 0);
      if (pv_a) begin
        if (pw == D_HT - 1) begin w = 0; h = ph + 1; end
        else begin w = pw + 1; h = ph; end
        check("a_pv_period", 32'(e - last_pv), 2);
        check("a_w", 32'(wp_a), w);
        check("a_h", 32'(hp_a), h);
        check("a_hs", 32'(hs_a), (w >= 656 && w <= 751) ? 0 : 1);
        check("a_vis", 32'(vis_a), (w < 640 && h < 480) ? 1 : 0);
        if (w == 0) begin
          if (line_start == 0) check("a_first_wrap_edge", 32'(e), 1601);
          else check("a_line_period", 32'(e - line_start), 1600);
          line_start = e;
        end
        pw = w; ph = h; last_pv = e;
      end
    end
    // Enable hold at widthPos=300.
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      @(negedge clk);
      if (pv_a && wp_a == 10'd300) found = 1'b1;
    end
    check("a_find_300", 32'(found), 1);
    en_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("a_hold_w", 32'(wp_a), 300);
      check("a_hold_h", 32'(hp_a), 2);
      check("a_hold_pv", 32'(pv_a), 0);
      check("a_hold_hs", 32'(hs_a), 1);
      check("a_hold_vis", 32'(vis_a), 1);
    end
    en_a = 1'b1;
    @(negedge clk);
    check("a_resume1_w", 32'(wp_a), 300);
    check("a_resume1_pv", 32'(pv_a), 0);
    @(negedge clk);
    check("a_resume2_w", 32'(wp_a), 301);
    check("a_resume2_pv", 32'(pv_a), 1);
  endtask

  task automatic test_b();
    int w, h;
    @(negedge clk);
    check("b_e1_w", 32'(wp_b), 0);
    check("b_e1_pv", 32'(pv_b), 0);
    check("b_e1_hs", 32'(hs_b), 0);
    check("b_e1_vis", 32'(vis_b), 1);
    for (int e = 2; e <= 1700; e++) begin
      @(negedge clk);
      w = (e - 1) % D_HT;
      h = (e - 1) / D_HT;
      check("b_pv_cont", 32'(pv_b), 1);
      check("b_w", 32'(wp_b), w);
      check("b_h", 32'(hp_b), h);
      check("b_hs", 32'(hs_b), (w >= 656 && w <= 751) ? 1 : 0);
    end
  endtask

  task automatic test_c();
    int w, h, first_fs, last_fs, n_fs;
    logic [22:0] exp_v;
    for (int k = 1; k <= 400; k++) begin
      w = k % C_HT;
      h = (k / C_HT) % C_VT;
      exp_v = {(w >= 10 && w < 13) ? 1'b0 : 1'b1,
               (h >= 5 && h < 7) ? 1'b0 : 1'b1,
               (w < C_HV && h < C_VV) ? 1'b1 : 1'b0,
               10'(h), 10'(w)};
      exp_q.push_back(exp_v);
    end
    first_fs = 0; last_fs = 0; n_fs = 0;
    for (int e = 1; e <= 3 * 400 + 1; e++) begin
      @(negedge clk);
      if (pv_c) begin
        if (exp_q.size() == 0) begin
          check("c_q_underflow", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("c_pix", 32'({hs_c, vs_c, vis_c, hp_c, wp_c}), 32'(exp_v));
          check("c_fs", 32'(fs_c), (exp_v[19:0] == 20'd0) ? 1 : 0);
        end
        if (fs_c) begin
          n_fs++;
          if (first_fs == 0) begin
            check("c_first_fs_edge", 32'(e), 433);
            first_fs = e;
          end else begin
            check("c_frame_period", 32'(e - last_fs), C_HT * C_VT * C_DIV);
          end
          last_fs = e;
        end
      end else begin
        check("c_fs_without_pv", 32'(fs_c), 0);
      end
    end
    check("c_q_drained", 32'(exp_q.size()), 0);
    check("c_fs_count", 32'(n_fs), 2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (57) @(negedge clk);
    check("a_pre_rst_w", 32'(wp_a), 28);
    // Asynchronous reset mid-line, between clock edges.
    #2 rst = 1'b1;
    #1;
    check("a_rst_w", 32'(wp_a), 0);
    check("a_rst_h", 32'(hp_a), 0);
    check("a_rst_hs", 32'(hs_a), 1);
    check("a_rst_vs", 32'(vs_a), 1);
    check("a_rst_vis", 32'(vis_a), 0);
    check("a_rst_pv", 32'(pv_a), 0);
    check("a_rst_fs", 32'(fs_a), 0);
    check("b_rst_hs", 32'(hs_b), 0);
    check("b_rst_vs", 32'(vs_b), 0);
    check("c_rst_w", 32'(wp_c), 0);
    @(negedge clk);
    rst = 1'b0;
    fork
      test_a();
      test_b();
      test_c();
    join
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
